// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch-side PC sequencing logic.
package riscv_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    TRAP  = 2'd3
  } pc_state_t;

  // Size of one instruction in bytes; sequential fetch steps by this amount.
  localparam int unsigned INSTR_BYTES = 4;

  // Conditional-branch funct3 encodings, shared with the comparator and decoder.
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // Value loaded into the flush counter on a redirect: the counter reaches
  // zero on the last cycle that flush is asserted.
  function automatic logic [2:0] flush_load(input int unsigned cycles);
    return 3'(cycles - 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_branch_target.sv
// Combinational redirect-target adder with misalignment detection.
module branch_target
  import riscv_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic         is_jalr,
  input  logic [n-1:0] pc,
  input  logic [n-1:0] imm,
  input  logic [n-1:0] rs1,
  output logic [n-1:0] target,
  output logic         misaligned
);

  logic [n-1:0] base;
  logic [n-1:0] sum;

  // JALR adds to rs1 and clears bit 0; branches and JAL are PC-relative.
  // A target with bit 1 set is not on an instruction boundary.
  always_comb begin
    base       = is_jalr ? rs1 : pc;
    sum        = base + imm;
    target     = is_jalr ? (sum & ~n'(1)) : sum;
    misaligned = target[1];
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter owner: sequential fetch, branch/jump redirect with
// a fixed-length IF/ID flush, and misaligned-target trapping.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned  n            = 32,
  parameter logic [n-1:0] RESET_PC     = '0,
  parameter int unsigned  FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         imem_ready,
  input  logic         ex_valid,
  input  logic         ex_is_branch,
  input  logic         ex_is_jal,
  input  logic         ex_is_jalr,
  input  logic         brnch,
  input  logic [n-1:0] ex_pc,
  input  logic [n-1:0] ex_imm,
  input  logic [n-1:0] ex_rs1,
  input  logic [n-1:0] trap_vec,
  input  logic         trap_ack,
  output logic [n-1:0] fetch_pc,
  output logic         fetch_req,
  output logic         flush,
  output logic         trap_valid,
  output logic [n-1:0] trap_addr,
  output logic [31:0]  taken_cnt
);

  localparam logic [n-1:0] STEP       = n'(INSTR_BYTES);
  localparam logic [2:0]   FLUSH_INIT = flush_load(FLUSH_CYCLES);
  // With a single flush cycle there is nothing to count, so skip FLUSH.
  localparam pc_state_t    POST_REDIR = (FLUSH_CYCLES == 1) ? RUN : FLUSH;

  pc_state_t    state_q, state_d;
  logic [n-1:0] fetch_pc_q, fetch_pc_d;
  logic         fetch_req_q, fetch_req_d;
  logic         flush_q, flush_d;
  logic         trap_valid_q, trap_valid_d;
  logic [n-1:0] trap_addr_q, trap_addr_d;
  logic [31:0]  taken_cnt_q, taken_cnt_d;
  logic [2:0]   flush_cnt_q, flush_cnt_d;

  logic [n-1:0] target;
  logic         misaligned;
  logic         taken;
  logic         advance;

  branch_target #(
    .n (n)
  ) u_target (
    .is_jalr    (ex_is_jalr),
    .pc         (ex_pc),
    .imm        (ex_imm),
    .rs1        (ex_rs1),
    .target     (target),
    .misaligned (misaligned)
  );

  // Redirect qualification and sequential-advance enable.
  always_comb begin
    taken   = ex_valid & ~stall & ~flush_q &
              ((ex_is_branch & brnch) | ex_is_jal | ex_is_jalr);
    advance = imem_ready & ~stall;
  end

  // Next-state and next-output computation for the fetch sequencer.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    fetch_req_d  = fetch_req_q;
    flush_d      = flush_q;
    trap_valid_d = trap_valid_q;
    trap_addr_d  = trap_addr_q;
    taken_cnt_d  = taken_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    case (state_q)
      BOOT: begin
        fetch_req_d = 1'b1;
        state_d     = RUN;
      end

      RUN: begin
        flush_d = 1'b0;
        if (taken) begin
          if (misaligned) begin
            fetch_req_d  = 1'b0;
            trap_valid_d = 1'b1;
            trap_addr_d  = target;
            state_d      = TRAP;
          end else begin
            fetch_pc_d  = target;
            flush_d     = 1'b1;
            taken_cnt_d = taken_cnt_q + 32'd1;
            flush_cnt_d = FLUSH_INIT;
            state_d     = POST_REDIR;
          end
        end else if (fetch_req_q && advance) begin
          fetch_pc_d = fetch_pc_q + STEP;
        end
      end

      FLUSH: begin
        fetch_req_d = 1'b1;
        if (advance) begin
          fetch_pc_d = fetch_pc_q + STEP;
        end
        if (flush_cnt_q == 3'd0) begin
          flush_d = 1'b0;
          state_d = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end

      TRAP: begin
        fetch_req_d = 1'b0;
        if (trap_ack) begin
          fetch_pc_d   = trap_vec & ~n'(3);
          trap_valid_d = 1'b0;
          fetch_req_d  = 1'b1;
          flush_d      = 1'b1;
          flush_cnt_d  = FLUSH_INIT;
          state_d      = POST_REDIR;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and output registers; reset overrides every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      fetch_pc_q   <= RESET_PC;
      fetch_req_q  <= 1'b0;
      flush_q      <= 1'b0;
      trap_valid_q <= 1'b0;
      trap_addr_q  <= '0;
      taken_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      fetch_req_q  <= fetch_req_d;
      flush_q      <= flush_d;
      trap_valid_q <= trap_valid_d;
      trap_addr_q  <= trap_addr_d;
      taken_cnt_q  <= taken_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign fetch_pc   = fetch_pc_q;
  assign fetch_req  = fetch_req_q;
  assign flush      = flush_q;
  assign trap_valid = trap_valid_q;
  assign trap_addr  = trap_addr_q;
  assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, all
// checked every cycle against a cycle-level behavioural model.
module tb_pc_sequencer;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic        ex_is_jal = 1'b0;
  logic        ex_is_jalr = 1'b0;
  logic        brnch = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_imm = '0;
  logic [31:0] ex_rs1 = '0;
  logic [31:0] trap_vec = '0;
  logic        trap_ack = 1'b0;
  logic [31:0] fetch_pc;
  logic        fetch_req;
  logic        flush;
  logic        trap_valid;
  logic [31:0] trap_addr;
  logic [31:0] taken_cnt;

  always #5 clk = ~clk;

  pc_sequencer #(
    .n            (32),
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .imem_ready   (imem_ready),
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_is_jal    (ex_is_jal),
    .ex_is_jalr   (ex_is_jalr),
    .brnch        (brnch),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .trap_vec     (trap_vec),
    .trap_ack     (trap_ack),
    .fetch_pc     (fetch_pc),
    .fetch_req    (fetch_req),
    .flush        (flush),
    .trap_valid   (trap_valid),
    .trap_addr    (trap_addr),
    .taken_cnt    (taken_cnt)
  );

  // Behavioural model: what the outputs should read after each edge.
  logic [31:0] m_pc, m_taddr, m_cnt;
  logic        m_req, m_flush, m_trap;
  bit          m_booting;
  int          m_flush_left;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [31:0] tgt;
    bit          redirect;
    if (reset) begin
      m_pc = 32'h0; m_req = 0; m_flush = 0; m_trap = 0; m_taddr = 0; m_cnt = 0;
      m_booting = 1; m_flush_left = 0;
    end else if (m_booting) begin
      m_booting = 0;
      m_req = 1;
    end else if (m_trap) begin
      if (trap_ack) begin
        m_pc = {trap_vec[31:2], 2'b00};
        m_trap = 0; m_req = 1; m_flush = 1; m_flush_left = FC;
      end
    end else if (m_flush_left > 0) begin
      if (imem_ready && !stall) m_pc = m_pc + 32'd4;
      m_flush_left--;
      m_flush = (m_flush_left > 0);
    end else begin
      m_flush = 0;
      redirect = ex_valid && !stall && ((ex_is_branch && brnch) || ex_is_jal || ex_is_jalr);
      if (ex_is_jalr) tgt = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
      else            tgt = ex_pc + ex_imm;
      if (redirect && ((tgt % 4) >= 2)) begin
        m_req = 0; m_trap = 1; m_taddr = tgt;
      end else if (redirect) begin
        m_pc = tgt; m_flush = 1; m_flush_left = FC; m_cnt = m_cnt + 1;
        // A single flush cycle ends in the very next step.
      end else if (imem_ready && !stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".fetch_pc"},   fetch_pc,          m_pc);
    chk({tag, ".fetch_req"},  {31'b0, fetch_req}, {31'b0, m_req});
    chk({tag, ".flush"},      {31'b0, flush},     {31'b0, m_flush});
    chk({tag, ".trap_valid"}, {31'b0, trap_valid}, {31'b0, m_trap});
    chk({tag, ".trap_addr"},  trap_addr,         m_taddr);
    chk({tag, ".taken_cnt"},  taken_cnt,         m_cnt);
  endtask

  // One clock: inputs were set on the falling edge; compare #1 after rise.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    tick(tag);
    $display("step %-12s pc=%h req=%0b flush=%0b trap=%0b taddr=%h cnt=%0d",
             tag, fetch_pc, fetch_req, flush, trap_valid, trap_addr, taken_cnt);
  endtask

  initial begin
    // Reset, BOOT, then sequential fetch.
    reset = 1; imem_ready = 1;
    step("reset");
    chk("boot_pc", fetch_pc, 32'h0);
    chk("boot_req", {31'b0, fetch_req}, 32'h0);
    reset = 0;
    step("boot");
    chk("run_pc0", fetch_pc, 32'h0);
    step("seq1");  chk("seq_pc4", fetch_pc, 32'h4);
    step("seq2");  chk("seq_pc8", fetch_pc, 32'h8);
    step("seq3");  chk("seq_pcC", fetch_pc, 32'hC);

    // BEQ taken, held in EX during the flush window.
    ex_valid = 1; ex_is_branch = 1; brnch = 1; ex_pc = 32'h100; ex_imm = 32'h20;
    step("beq");
    chk("beq_pc", fetch_pc, 32'h120);
    chk("beq_flush", {31'b0, flush}, 32'h1);
    chk("beq_cnt", taken_cnt, 32'h1);
    step("beq_fl2");
    chk("beq_ignored", fetch_pc, 32'h124);
    chk("beq_flush2", {31'b0, flush}, 32'h1);
    ex_valid = 0;
    step("beq_done");
    chk("beq_unflush", {31'b0, flush}, 32'h0);

    // Branch not taken.
    ex_valid = 1; brnch = 0;
    step("bnt");
    chk("bnt_pc", fetch_pc, 32'h12C);
    chk("bnt_cnt", taken_cnt, 32'h1);

    // JALR clears bit 0 of the target.
    ex_is_branch = 0; ex_is_jalr = 1; ex_rs1 = 32'h201; ex_imm = 32'h4;
    step("jalr");
    chk("jalr_pc", fetch_pc, 32'h204);
    chk("jalr_flush", {31'b0, flush}, 32'h1);
    ex_valid = 0; ex_is_jalr = 0;
    step("jalr_fl2");
    step("jalr_done");

    // Misaligned JAL traps until acknowledged.
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h100; ex_imm = 32'h6;
    step("jal_mis");
    chk("trap_valid", {31'b0, trap_valid}, 32'h1);
    chk("trap_addr", trap_addr, 32'h106);
    chk("trap_req", {31'b0, fetch_req}, 32'h0);
    ex_valid = 0; ex_is_jal = 0;
    step("trap_hold");
    chk("trap_hold_req", {31'b0, fetch_req}, 32'h0);
    trap_vec = 32'h80; trap_ack = 1;
    step("trap_ack");
    chk("trap_vec_pc", fetch_pc, 32'h80);
    chk("trap_flush", {31'b0, flush}, 32'h1);
    trap_ack = 0;
    step("trap_fl2");
    step("trap_done");

    // Stall holds a taken branch; redirect follows once stall drops.
    ex_valid = 1; ex_is_branch = 1; brnch = 1; ex_pc = 32'h300; ex_imm = 32'h10; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall_pc", fetch_pc, 32'h88);
    end
    stall = 0;
    step("unstall");
    chk("unstall_pc", fetch_pc, 32'h310);

    // Reset in the middle of a flush.
    ex_valid = 0; reset = 1;
    step("rst_flush");
    chk("rst_pc", fetch_pc, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    reset = 0;

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      int op;
      reset      = ($urandom_range(0, 199) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      ex_valid   = $urandom_range(0, 1) == 1;
      op         = $urandom_range(0, 3);
      ex_is_branch = (op == 0);
      ex_is_jal    = (op == 1);
      ex_is_jalr   = (op == 2);
      brnch      = $urandom_range(0, 1) == 1;
      ex_pc      = {$urandom_range(0, 16'hFFFF), 2'b00};
      ex_imm     = 32'($urandom_range(0, 2047)) * 2 - 32'd2048;
      ex_rs1     = $urandom;
      trap_vec   = $urandom;
      trap_ack   = ($urandom_range(0, 2) == 0);
      tick("rand");
    end
    $display("random phase complete, taken_cnt=%0d", taken_cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
